// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Bundle of config handshake, control, serial input and status signals.
// Latency: n/a (wires only).
// Backpressure: cfg_ready gates the config handshake; the serial stream has none.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             din;
  logic             din_valid;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  // Stimulus side: offers config, control and serial data.
  modport master (
    output cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    output start, abort, din, din_valid,
    input  cfg_ready, out, match_count, busy, done
  );

  // Detector side.
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_overlap, cfg_target,
    input  start, abort, din, din_valid,
    output cfg_ready, out, match_count, busy, done
  );

endinterface

// File: rtl/seq_detect_ctrl_pattern_matcher.sv
// History shift register, fill counter and pattern compare.
// Latency: hit is combinational on the shifting edge; match is hit registered (1 cycle).
// Backpressure: none; shift_en low holds history and fill (a bubble).
module pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              match_q, match_d;

  // Shift in qualified bits, compare the updated window, rewind fill on a
  // non-overlapping match so the next hit needs PAT_W fresh bits.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit        = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hit    = (hist_shift == pattern) && (fill_inc == FILL_FULL);
      hist_d = hist_shift;
      fill_d = (hit && !overlap) ? '0 : fill_inc;
    end
    match_d = hit;
  end

  // Window state and the registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: config regs, run/done FSM, match counter.
// Latency: bit sampled at edge k -> out/match_count in cycle k+1; start -> busy next cycle.
// Backpressure: cfg_ready low while RUN stalls config; serial input is never stalled.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  seq_detect_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_rdy;
  logic             clear;
  logic             shift_en;
  logic             hit;
  logic             match;

  // Config may load in any state but RUN; start arms from IDLE or DONE and
  // clears the window; abort beats a match on the same edge by masking the shift.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    ovl_d    = ovl_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    cfg_rdy  = (state_q != ST_RUN);
    clear    = 1'b0;
    shift_en = (state_q == ST_RUN) && bus.din_valid && !bus.abort;
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    if (bus.cfg_valid && cfg_rdy) begin
      pat_d = bus.cfg_pattern;
      ovl_d = bus.cfg_overlap;
      tgt_d = bus.cfg_target;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          cnt_d = cnt_inc;
          if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // FSM, config and counter registers with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  pattern_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (bus.din),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .hit      (hit),
    .match    (match)
  );

  assign bus.cfg_ready   = cfg_rdy;
  assign bus.out         = match;
  assign bus.match_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench: expected pulses go into a scoreboard queue, a negedge
// monitor pops one per out pulse and compares count/done/busy.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;
  int   exp_tgt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected pulse (if any) before the edge that samples the bit.
  task automatic send_bit(input logic b, input logic exp_hit);
    exp_t e;
    if (exp_hit) begin
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      e.cnt   = 8'(exp_cnt);
      e.done  = (exp_tgt != 0) && (exp_cnt == exp_tgt);
      sbq.push_back(e);
    end
    bus.din       = b;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
  endtask

  // Bits/hits/bubbles are MSB-first vectors of length n.
  task automatic run_stream(input logic [31:0] bits, input int n,
                            input logic [31:0] hits, input logic [31:0] bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles[n-1-i]) begin
        bus.din       = ~bits[n-1-i];
        bus.din_valid = 1'b0;
        step();
      end
      send_bit(bits[n-1-i], hits[n-1-i]);
    end
  endtask

  task automatic configure(input logic [3:0] pat, input logic ovl, input logic [7:0] tgt);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_overlap = ovl;
    bus.cfg_target  = tgt;
    check("cfg_ready when offered", bus.cfg_ready, 1);
    step();
    bus.cfg_valid = 1'b0;
    exp_tgt = int'(tgt);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_cnt = 0;
    check("busy after start", bus.busy, 1);
    check("done after start", bus.done, 0);
    check("count after start", bus.match_count, 0);
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  task automatic expect_drained();
    step();
    step();
    check("pending pulses", sbq.size(), 0);
  endtask

  // Scoreboard monitor: every out pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected out pulse", bus.out, 0);
        end else begin
          e = sbq.pop_front();
          check("pulse match_count", bus.match_count, e.cnt);
          check("pulse done", bus.done, e.done);
          check("pulse busy", bus.busy, !e.done);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.din         = 1'b0;
    bus.din_valid   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out", bus.out, 0);
    check("reset match_count", bus.match_count, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset cfg_ready", bus.cfg_ready, 1);
    rst = 1'b1;
    step();

    // 1011 non-overlap: single hit on bit 4.
    configure(4'b1011, 1'b0, 8'd0);
    do_start();
    run_stream(7'b1011011, 7, 7'b0001000, 0);
    expect_drained();
    check("t1 count", bus.match_count, 1);
    check("t1 busy", bus.busy, 1);
    do_abort();
    check("abort busy", bus.busy, 0);
    check("abort holds count", bus.match_count, 1);

    // Overlap: hits on bits 4 and 7; start mid-run is ignored.
    configure(4'b1011, 1'b1, 8'd0);
    do_start();
    run_stream(4'b1011, 4, 4'b0001, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start in RUN count", bus.match_count, 1);
    run_stream(3'b011, 3, 3'b001, 0);
    expect_drained();
    check("t2 count", bus.match_count, 2);
    do_abort();

    // Quota 2 with bubbles inside each pattern; DONE blocks further hits.
    configure(4'b1011, 1'b0, 8'd2);
    do_start();
    run_stream(8'b10111011, 8, 8'b00010001, 8'b01000100);
    check("t3 done", bus.done, 1);
    check("t3 busy", bus.busy, 0);
    check("t3 count", bus.match_count, 2);
    run_stream(4'b1011, 4, 0, 0);
    expect_drained();
    check("t3 count held", bus.match_count, 2);

    // Config offered during RUN stalls, loads once DONE is reached.
    do_start();
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = 4'b0110;
    bus.cfg_overlap = 1'b1;
    bus.cfg_target  = 8'd1;
    step();
    check("cfg_ready in RUN", bus.cfg_ready, 0);
    run_stream(8'b10111011, 8, 8'b00010001, 0);
    check("cfg_ready in DONE", bus.cfg_ready, 1);
    check("t4 done", bus.done, 1);
    step();
    bus.cfg_valid = 1'b0;
    exp_tgt = 1;
    check("done after cfg in DONE", bus.done, 1);
    do_start();
    run_stream(4'b0110, 4, 4'b0001, 0);
    expect_drained();
    check("t4 new cfg done", bus.done, 1);

    // Abort on the completing bit: no pulse, no count, back to IDLE.
    configure(4'b1011, 1'b0, 8'd0);
    check("cfg keeps DONE", bus.done, 1);
    do_start();
    run_stream(3'b101, 3, 0, 0);
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    bus.abort     = 1'b1;
    step();
    bus.din_valid = 1'b0;
    bus.abort     = 1'b0;
    check("t5 out", bus.out, 0);
    check("t5 count", bus.match_count, 0);
    check("t5 busy", bus.busy, 0);
    check("t5 done", bus.done, 0);
    expect_drained();

    // Asynchronous reset mid-pattern, then a fresh run sees no stale history.
    do_start();
    run_stream(7'b1011101, 7, 7'b0001000, 0);
    rst = 1'b0;
    #1;
    check("arst out", bus.out, 0);
    check("arst match_count", bus.match_count, 0);
    check("arst busy", bus.busy, 0);
    check("arst done", bus.done, 0);
    check("arst cfg_ready", bus.cfg_ready, 1);
    step();
    rst = 1'b1;
    step();
    configure(4'b1011, 1'b0, 8'd0);
    do_start();
    run_stream(3'b011, 3, 0, 0);
    expect_drained();
    check("t6 no stale match", bus.match_count, 0);
    run_stream(4'b1011, 4, 4'b0001, 0);
    expect_drained();
    check("t6 count", bus.match_count, 1);
    do_abort();

    // Unlimited quota: 257 overlapping hits, count saturates at 255.
    configure(4'b0000, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 260; i++) send_bit(1'b0, i >= 3);
    expect_drained();
    check("sat count", bus.match_count, 255);
    check("sat busy", bus.busy, 1);
    do_abort();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial pattern-detector controller. It accepts a PAT_W-bit target pattern, an overlap/non-overlap mode and a match quota through a configuration handshake. It then arms on `start` and scans a qualified serial bit stream, pulsing `out` on each match and counting matches until the quota is reached. It sequences and configures the fixed-pattern detector datapath so one block serves every pattern and mode in the design.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (2..16)
- CNT_W, 8, width of match quota and match counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid
- cfg_pattern  in  PAT_W  target pattern; MSB is the first bit received
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  in  CNT_W  match quota; 0 = unlimited
- start  in  1  arm the detector (single-cycle pulse)
- abort  in  1  stop scanning, return to IDLE
- din  in  1  serial data bit
- din_valid  in  1  din is sampled on this edge only when high
- out  out  1  one-cycle match pulse
- match_count  out  CNT_W  matches since last start
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: out=0, match_count=0, busy=0, done=0, cfg_ready=1. Config registers reset to pattern=0, overlap=0, target=0.
- cfg_ready = (state != RUN). Config registers load on cfg_valid & cfg_ready.
- IDLE/DONE + start → RUN. On that edge:
  - history shift register is cleared
  - fill counter is set to 0
  - match_count is set to 0
  - done is cleared
- If cfg_valid and start occur in the same cycle, the new config is used for the run.
- In RUN, each edge with din_valid=1:
  - history = {history[PAT_W-2:0], din}
  - fill increments, saturating at PAT_W
- Match condition: the updated history == pattern and the updated fill == PAT_W.
  - On a match, out=1 for the following cycle and match_count increments.
  - Overlap mode: fill stays at PAT_W.
  - Non-overlap mode: fill resets to 0, so the next match needs PAT_W fresh bits.
- din_valid=0 holds history and fill unchanged (a bubble, not a break).
- Quota: if target≠0 and match_count reaches target on a match edge, go to DONE on that edge. done=1 and busy=0 from the next cycle.
- Unlimited mode (target=0): match_count saturates at 2^CNT_W−1. out still pulses on every match.
- abort in RUN → IDLE. match_count is held and out=0.
- abort outside RUN has no effect.
- abort has priority over a match on the same edge: no pulse and no count.
- start while in RUN is ignored.
- DONE holds until start (→RUN) or abort-free config (stays DONE, config loads).
- rst deasserted mid-run returns everything to reset values immediately, asynchronously.

## Timing
- din sampled at edge k → out and match_count valid in cycle k+1 (1-cycle latency). out is never high for two consecutive cycles in non-overlap mode when PAT_W≥2.
- start at edge s → busy=1 from cycle s+1. The first bit eligible for sampling is at edge s+1.
- The final match at edge m → out=1, done=1, busy=0 all in cycle m+1.
- The config handshake completes in the same cycle. A config offered during RUN stalls (cfg_ready=0) until the FSM leaves RUN.

## Structure
- Package seq_detect_pkg:
  - state enum (IDLE, RUN, DONE)
  - default PAT_W/CNT_W constants
- One sub-module, pattern_matcher:
  - contains the history shift register, the fill counter and the compare
  - inputs: clear, shift_en, bit, pattern, overlap
  - output: registered match
- Controller FSM, config registers and match counter live in seq_detect_ctrl.

## Test plan
- Config pattern 1011, non-overlap, target 0; start; stream 1,0,1,1,0,1,1 → one out pulse the cycle after bit 4; match_count=1.
- Same stream, overlap=1 → pulses after bits 4 and 7; match_count=2.
- Pattern 1011, target 2, stream 1011 1011 with din_valid bubbles inserted mid-pattern → pulses after each completing bit; done=1, busy=0 after the second match; further bits produce no pulse.
- cfg_valid held during RUN → cfg_ready=0 and config unchanged; accepted the cycle the FSM enters DONE.
- abort on the same edge as the completing bit → no pulse, match_count unchanged, state IDLE.
- rst pulled low mid-pattern → all outputs 0 immediately. After release and start, partial history is gone: stream 011 does not match 1011.
